// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the instruction fetch front end.
//   NOP_INSTR      : add $0,$0,$0, presented whenever no instruction is ready
//   PC_STEP        : byte distance between consecutive instruction words
//   fetch_state_t  : prefetch FSM states (RUN fetches, FLUSH drains stale data)
//   fetch_entry_t  : one queue entry, instruction word plus its PC+4
//   word_align     : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0020;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] next_pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// ---------------------------------------------------------------------------
// instr_fifo
// Synchronous in-order FIFO used as the prefetch queue.
//   CLK, RST_N : clock, asynchronous active-low reset
//   push, din  : write din at the clock edge (accepted when not full, or when
//                a pop frees the slot in the same cycle)
//   pop        : retire the head at the clock edge (ignored when empty)
//   flush      : empty the FIFO at the clock edge; overrides push and pop
//   dout       : head entry, valid only while !empty
//   empty/full : occupancy flags
//   count      : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap without extra logic.
// ---------------------------------------------------------------------------
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // At full the slot under wr_ptr is the head being popped, so a same-cycle
  // push may overwrite it: the head is read combinationally before the edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; empty masks whatever it holds.
  always_ff @(posedge CLK) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The owner gates pop with !empty; a pop on empty means broken control.
  a_no_pop_empty: assert property (@(posedge CLK) disable iff (!RST_N)
    !(pop && empty && !flush));

endmodule

// File: rtl/instr_prefetch_queue.sv
// ---------------------------------------------------------------------------
// instr_prefetch_queue
// Instruction fetch front end feeding the IF/ID buffer. Owns the fetch PC,
// issues word requests to a variable-latency instruction memory, buffers the
// returned words in order and presents them with their PC+4.
//
// Handshakes:
//   Request : imem_req_valid/imem_req_ready. A transfer happens on a clock
//             edge where both are 1. Once raised, valid and addr stay stable
//             until the transfer, except that a redirect may withdraw the
//             request. Valid is only raised while the credit rule allows it.
//   Response: imem_rsp_valid carries one word per cycle, in request order,
//             with no back-pressure.
//   Consumer: instr_valid is 1 while the queue holds an entry; the head is
//             popped at an edge where instr_valid && !stall && !redirect_valid.
//
// Ports:
//   CLK, RST_N                      clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       fetch request channel (word aligned)
//   imem_rsp_valid/data             fetch response channel
//   redirect_valid, redirect_pc     taken branch/jump from MEM, highest priority
//   stall                           load-use stall, holds the head entry
//   instr_valid, instr, instr_next_pc  head of queue (NOP and 0 when empty)
//   fetch_state                     current FSM state for observation
// ---------------------------------------------------------------------------
module instr_prefetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         RST_N,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [31:0]  imem_req_addr,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         stall,
  output logic         instr_valid,
  output logic [31:0]  instr,
  output logic [31:0]  instr_next_pc,
  output fetch_state_t fetch_state
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_state_t  state_q;
  fetch_state_t  state_d;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   fetch_pc_d;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] outstanding_d;

  logic          req_accept;
  logic          rsp_take;
  logic [CW:0]   in_flight;
  logic [31:0]   rsp_next_pc;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_din;
  fetch_entry_t  fifo_dout;

  // -------------------------------------------------------------------------
  // Credit: every word already queued or still in flight owns a queue slot,
  // so a response can always be pushed without a full check.
  // -------------------------------------------------------------------------
  assign in_flight = {1'b0, fifo_count} + {1'b0, outstanding_q};

  // RST_N is folded in so the request drops asynchronously with reset even
  // though the registered state already reads RUN.
  assign imem_req_valid = RST_N && (state_q == RUN) &&
                          (in_flight < (CW + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_accept     = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding (one that was in flight across a
  // reset) belongs to no request of ours and is ignored.
  assign rsp_take = imem_rsp_valid && (outstanding_q != '0);

  // In RUN the outstanding requests are the consecutive words just below
  // fetch_pc, so the oldest one was issued at fetch_pc - 4*outstanding and
  // its PC+4 follows directly.
  assign rsp_next_pc = fetch_pc_q - (32'(outstanding_q) * PC_STEP) + PC_STEP;

  assign outstanding_d = outstanding_q + CW'(req_accept) - CW'(rsp_take);

  // -------------------------------------------------------------------------
  // Queue control. A redirect flushes the queue and kills both the push of
  // any response arriving that cycle and the consumer's pop.
  // -------------------------------------------------------------------------
  assign fifo_push = rsp_take && (state_q == RUN) && !redirect_valid;
  assign fifo_pop  = !fifo_empty && !stall && !redirect_valid;
  assign fifo_din  = '{instr: imem_rsp_data, next_pc: rsp_next_pc};

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // -------------------------------------------------------------------------
  // FSM and fetch PC.
  // A redirect always wins. Requests accepted in the redirect cycle are stale
  // and are already counted in outstanding_d, so FLUSH is entered whenever
  // anything is still due back after this edge. FLUSH drains responses
  // without enqueueing them and returns to RUN on the edge where the last one
  // is consumed; fetching restarts from fetch_pc on the following cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (req_accept) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      state_d    = (outstanding_d != '0) ? FLUSH : RUN;
    end else if ((state_q == FLUSH) && (outstanding_d == '0)) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
    end
  end

  // -------------------------------------------------------------------------
  // Head presentation.
  // -------------------------------------------------------------------------
  assign instr_valid   = !fifo_empty;
  assign instr         = fifo_empty ? NOP_INSTR : fifo_dout.instr;
  assign instr_next_pc = fifo_empty ? 32'h0000_0000 : fifo_dout.next_pc;
  assign fetch_state   = state_q;

  // The credit rule makes a push into a full queue impossible unless the
  // head leaves in the same cycle.
  a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
    !(fifo_push && fifo_full && !fifo_pop));

  // Requests are only issued under credit, so outstanding never passes DEPTH.
  a_outstanding_bound: assert property (@(posedge CLK) disable iff (!RST_N)
    outstanding_q <= CW'(DEPTH));

  // No request may be accepted while draining stale responses.
  a_no_req_in_flush: assert property (@(posedge CLK) disable iff (!RST_N)
    !((state_q == FLUSH) && imem_req_valid));

endmodule
